// File: rtl/ibex_rf_write_sched_if.sv
// Write-port bundle between the writeback/aux requesters, the scheduler and the register file.
// master drives requests and observes ready/rf_*; slave is the scheduler.
interface ibex_rf_write_sched_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 wb_we;
  logic [4:0]           wb_waddr;
  logic [DataWidth-1:0] wb_wdata;
  logic                 wb_ready;
  logic                 aux_valid;
  logic [4:0]           aux_waddr;
  logic [DataWidth-1:0] aux_wdata;
  logic                 aux_ready;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [DataWidth-1:0] rf_wdata;

  modport master (
    output wb_we, wb_waddr, wb_wdata, aux_valid, aux_waddr, aux_wdata,
    input  wb_ready, aux_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, aux_valid, aux_waddr, aux_wdata,
    output wb_ready, aux_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/ibex_rf_write_sched.sv
// Write-port scheduler for the latch register file: clearing sweep, then wb/aux arbitration.
// Define IBEX_RF_WSCHED_AUX_EN to enable the aux port and its starvation counter.
module ibex_rf_write_sched #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter bit                   InitOnReset = 1'b1,
  parameter int unsigned          MaxAuxWait  = 4
) (
  input  logic                        clk_int,
  input  logic                        rst_ni,
  input  logic                        init_req_i,
  output logic                        init_busy_o,
  output logic                        init_done_o,
  output logic                        err_o,
  ibex_rf_write_sched_if.slave        bus
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [4:0] LastWord = RV32E ? 5'd15 : 5'd31;

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 boost, wb_ready, aux_ready, wb_acc, sel_aux;
  logic [4:0]           req_addr, addr_eff;
  logic [DataWidth-1:0] req_data;

`ifdef IBEX_RF_WSCHED_AUX_EN
  localparam int unsigned WaitW = $clog2(MaxAuxWait + 1);

  logic [WaitW-1:0] wait_q, wait_d;

  assign boost     = (wait_q == WaitW'(MaxAuxWait));
  assign aux_ready = (state_q == StRun) && bus.aux_valid && (!bus.wb_we || boost);

  always_comb begin
    wait_d = wait_q;
    if (!bus.aux_valid || aux_ready) begin
      wait_d = '0;
    end else if (!boost) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_aux;

  assign boost      = 1'b0;
  assign aux_ready  = 1'b0;
  assign unused_aux = ^{bus.aux_valid, MaxAuxWait};
`endif

  assign wb_ready = (state_q == StRun) && !boost;
  assign wb_acc   = bus.wb_we && wb_ready;
  // aux_ready already implies RUN and a valid aux request; wb wins unless boosted.
  assign sel_aux  = aux_ready && !wb_acc;
  assign req_addr = sel_aux ? bus.aux_waddr : bus.wb_waddr;
  assign req_data = sel_aux ? bus.aux_wdata : bus.wb_wdata;
  assign addr_eff = RV32E ? {1'b0, req_addr[3:0]} : req_addr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    done_d     = 1'b0;
    err_d      = err_q | (bus.wb_we && (state_q == StInit));

    unique case (state_q)
      StInit: begin
        // Word 0 is hardwired zero, so the sweep starts at 1.
        rf_we_d    = 1'b1;
        rf_waddr_d = cnt_q;
        rf_wdata_d = WordZeroVal;
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == LastWord) begin
          state_d = StRun;
          cnt_d   = 5'd1;
          done_d  = 1'b1;
        end
      end
      StRun: begin
        if (wb_acc || sel_aux) begin
          rf_we_d    = (addr_eff != 5'd0);
          rf_waddr_d = addr_eff;
          rf_wdata_d = req_data;
        end
        if (init_req_i) begin
          state_d = StInit;
          cnt_d   = 5'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= InitOnReset ? StInit : StRun;
      cnt_q      <= 5'd1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= WordZeroVal;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.wb_ready  = wb_ready;
  assign bus.aux_ready = aux_ready;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign init_busy_o   = (state_q == StInit);
  assign init_done_o   = done_q;
  assign err_o         = err_q;

endmodule
